// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: steps the operand at most STEP positions per cycle behind a valid/ready pair.
// Define SHIFT_SEQ_ROTATE_EN to make op 2'b10 a rotate-left; otherwise it behaves as SLL.
module shift_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 5,
    parameter int STEP        = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHIFT_WIDTH-1:0] shift_value_i,
    input  logic [1:0]             op_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SHIFT_WIDTH-1:0] STEP_L = SHIFT_WIDTH'(STEP);

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  work_q, work_d, shifted;
    logic [SHIFT_WIDTH-1:0] rem_q, rem_d, step_amt;
    logic [1:0]             op_q, op_d;

    assign step_amt = (rem_q < STEP_L) ? rem_q : STEP_L;

    // One step of the shift; each step is exact, so steps compose into a shift by n.
    always_comb begin
        shifted = work_q << step_amt;
        case (op_q)
            2'b01:   shifted = work_q >> step_amt;
            2'b11:   shifted = $signed(work_q) >>> step_amt;
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b10:   shifted = (work_q << step_amt) | (work_q >> (DATA_WIDTH - int'(step_amt)));
`endif
            default: shifted = work_q << step_amt;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    work_d  = data_i;
                    rem_d   = shift_value_i;
                    op_d    = op_i;
                    state_d = (shift_value_i == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step_amt;
                if (rem_d == '0) state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = !in_ready_o;
    assign data_o      = work_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus backpressure and mid-shift reset sequences.
module tb_shift_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_i, in_valid_i, out_ready_i;
    logic [31:0] data_i;
    logic [4:0]  shift_value_i;
    logic [1:0]  op_i;
    logic        in_ready_o, out_valid_o, busy_o;
    logic [31:0] data_o;

    int n_chk = 0;
    int n_fail = 0;

    shift_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_i(data_i), .shift_value_i(shift_value_i), .op_i(op_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  n;
        logic [1:0]  op;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request, scramble the inputs after the accept edge, count edges to out_valid.
    task automatic do_req(input logic [31:0] d, input logic [4:0] n, input logic [1:0] op,
                          output logic [31:0] res, output int lat);
        int w = 0;
        while (!in_ready_o && w < 50) begin tick(); w++; end
        check("in_ready_before_req", {31'b0, in_ready_o}, 32'd1);
        in_valid_i = 1'b1; data_i = d; shift_value_i = n; op_i = op;
        tick();
        in_valid_i = 1'b0; data_i = 32'h5a5a_a5a5; shift_value_i = 5'd7; op_i = 2'b01;
        lat = 0;
        while (!out_valid_o && lat < 100) begin tick(); lat++; end
        res = data_o;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("in_ready_after_handshake", {31'b0, in_ready_o}, 32'd1);
    endtask

    initial begin
        logic [31:0] res;
        int lat;

        vecs[0]  = '{32'h0000_0001, 5'd10, 2'b00, 32'h0000_0400, 3};
        vecs[1]  = '{32'hfedc_ba98, 5'd4,  2'b01, 32'h0fed_cba9, 1};
        vecs[2]  = '{32'hfedc_ba98, 5'd4,  2'b11, 32'hffed_cba9, 1};
        vecs[3]  = '{32'hfedc_ba98, 5'd0,  2'b00, 32'hfedc_ba98, 0};
        vecs[4]  = '{32'hfedc_ba98, 5'd31, 2'b11, 32'hffff_ffff, 8};
        vecs[5]  = '{32'hfedc_ba98, 5'd31, 2'b01, 32'h0000_0001, 8};
        vecs[6]  = '{32'h8000_0001, 5'd5,  2'b00, 32'h0000_0020, 2};
        vecs[7]  = '{32'h1234_5678, 5'd8,  2'b01, 32'h0012_3456, 2};
        vecs[8]  = '{32'h8000_0000, 5'd13, 2'b11, 32'hfffc_0000, 4};
`ifdef SHIFT_SEQ_ROTATE_EN
        vecs[9]  = '{32'hfedc_ba98, 5'd4,  2'b10, 32'hedcb_a98f, 1};
        vecs[10] = '{32'hfedc_ba98, 5'd12, 2'b10, 32'hcba9_8fed, 3};
`else
        vecs[9]  = '{32'hfedc_ba98, 5'd4,  2'b10, 32'hedcb_a980, 1};
        vecs[10] = '{32'hfedc_ba98, 5'd12, 2'b10, 32'hcba9_8000, 3};
`endif

        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        data_i = '0; shift_value_i = '0; op_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        check("reset_in_ready",  {31'b0, in_ready_o},  32'd1);
        check("reset_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("reset_busy",      {31'b0, busy_o},      32'd0);
        check("reset_data",      data_o,               32'h0);
        tick();
        check("idle_hold_in_ready", {31'b0, in_ready_o}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i].data, vecs[i].n, vecs[i].op, res, lat);
            check($sformatf("vec%0d_data", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: new requests must be ignored while DONE waits for out_ready.
        in_valid_i = 1'b1; data_i = 32'hfedc_ba98; shift_value_i = 5'd4; op_i = 2'b01;
        tick();
        in_valid_i = 1'b1; data_i = 32'h1111_1111; shift_value_i = 5'd0; op_i = 2'b00;
        tick();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_out_valid", c), {31'b0, out_valid_o}, 32'd1);
            check($sformatf("bp%0d_in_ready", c),  {31'b0, in_ready_o},  32'd0);
            check($sformatf("bp%0d_busy", c),      {31'b0, busy_o},      32'd1);
            check($sformatf("bp%0d_data", c),      data_o,               32'h0fed_cba9);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("bp_idle_after_hs_in_ready", {31'b0, in_ready_o},  32'd1);
        check("bp_idle_after_hs_valid",    {31'b0, out_valid_o}, 32'd0);
        check("bp_not_captured_data",      data_o,               32'h0fed_cba9);
        tick();
        in_valid_i = 1'b0;
        check("bp_late_accept_valid", {31'b0, out_valid_o}, 32'd1);
        check("bp_late_accept_data",  data_o,               32'h1111_1111);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // Reset in the middle of a 5-step shift discards the transaction.
        in_valid_i = 1'b1; data_i = 32'h0000_0001; shift_value_i = 5'd20; op_i = 2'b00;
        tick();
        in_valid_i = 1'b0;
        tick();
        check("mid_busy_before_reset", {31'b0, busy_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_reset_in_ready",  {31'b0, in_ready_o},  32'd1);
        check("mid_reset_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("mid_reset_busy",      {31'b0, busy_o},      32'd0);
        check("mid_reset_data",      data_o,               32'h0);
        begin
            int seen = 0;
            for (int c = 0; c < 10; c++) begin
                if (out_valid_o) seen++;
                tick();
            end
            check("mid_reset_no_valid_pulse", 32'(seen), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
